// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: states and opcodes shared by the SPI flash responder and controller
package spi_flash_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_ID,
        S_IGNORE
    } spi_resp_state_t;

    localparam logic [7:0] SPI_CMD_READ  = 8'h03;
    localparam logic [7:0] SPI_CMD_JEDEC = 8'h9F;
    localparam int         SPI_ADDR_BITS = 24;
endpackage

// File: rtl/spi_flash_responder_if.sv
// spi_flash_responder_if: four-wire SPI link between flash controller and responder
interface spi_flash_responder_if;
    logic SPI_CS;
    logic SPI_SCK;
    logic SPI_SI;
    logic SPI_SO;

    modport master (output SPI_CS, SPI_SCK, SPI_SI, input SPI_SO);
    modport slave  (input SPI_CS, SPI_SCK, SPI_SI, output SPI_SO);
endinterface

// File: rtl/spi_in_sync.sv
// spi_in_sync: two-flop synchroniser for CS/SCK/SI plus SCK edge detection
module spi_in_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic cs_n_in,
    input  logic sck_in,
    input  logic si_in,
    output logic cs_n,
    output logic si,
    output logic sck_rise,
    output logic sck_fall
);
    logic [1:0] cs_q, cs_d;
    logic [1:0] sck_q, sck_d;
    logic [1:0] si_q, si_d;
    logic       sck_prev_q, sck_prev_d;

    always_comb begin
        cs_d       = {cs_q[0], cs_n_in};
        sck_d      = {sck_q[0], sck_in};
        si_d       = {si_q[0], si_in};
        sck_prev_d = sck_q[1];
    end

    // CS resets deasserted so the responder does not see a phantom transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q       <= 2'b11;
            sck_q      <= 2'b00;
            si_q       <= 2'b00;
            sck_prev_q <= 1'b0;
        end else begin
            cs_q       <= cs_d;
            sck_q      <= sck_d;
            si_q       <= si_d;
            sck_prev_q <= sck_prev_d;
        end
    end

    assign cs_n     = cs_q[1];
    assign si       = si_q[1];
    assign sck_rise = sck_q[1] & ~sck_prev_q;
    assign sck_fall = ~sck_q[1] & sck_prev_q;
endmodule

// File: rtl/spi_flash_responder.sv
// spi_flash_responder: device end of an SPI flash link serving READ and JEDEC ID from a ROM port
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int          ADDR_W   = 20,
    parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
    input  logic                 CLK,
    input  logic                 resetn,
    spi_flash_responder_if.slave spi,
    output logic                 rom_rd_en,
    output logic [ADDR_W-1:0]    rom_addr,
    input  logic [7:0]           rom_data,
    output logic                 active,
    output logic [7:0]           last_cmd
);
    localparam logic [4:0] ADDR_LAST = 5'(SPI_ADDR_BITS - 1);
    localparam logic [4:0] ADDR_DONE = 5'(SPI_ADDR_BITS);

    logic cs_n, si, sck_rise, sck_fall;

    spi_in_sync u_sync (
        .clk      (CLK),
        .rst_n    (resetn),
        .cs_n_in  (spi.SPI_CS),
        .sck_in   (spi.SPI_SCK),
        .si_in    (spi.SPI_SI),
        .cs_n     (cs_n),
        .si       (si),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall)
    );

    spi_resp_state_t   state_q, state_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shreg_q, shreg_d;
    logic [ADDR_W-2:0] addr_q, addr_d;
    logic [7:0]        next_byte_q, next_byte_d;
    logic [1:0]        id_idx_q, id_idx_d;
    logic              rose_q, rose_d;
    logic              rd_q, rd_d;
    logic              rd_dly_q, rd_dly_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [7:0]        last_cmd_q, last_cmd_d;
    logic [7:0]        cmd_byte, id_byte;
    logic [ADDR_W-1:0] full_addr;

    assign cmd_byte  = {shreg_q[6:0], si};
    assign full_addr = {addr_q, si};
    assign id_byte   = id_idx_q == 2'd0 ? JEDEC_ID[15:8] : id_idx_q == 2'd1 ? JEDEC_ID[7:0] : 8'hFF;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        addr_d      = addr_q;
        next_byte_d = next_byte_q;
        id_idx_d    = id_idx_q;
        rose_d      = rose_q;
        rd_d        = 1'b0;
        rd_dly_d    = rd_q;
        rom_addr_d  = rom_addr_q;
        last_cmd_d  = last_cmd_q;
        if (cs_n && state_q != S_IDLE) begin
            state_d     = S_IDLE;
            bit_cnt_d   = '0;
            shreg_d     = '0;
            addr_d      = '0;
            next_byte_d = '0;
            id_idx_d    = '0;
            rose_d      = 1'b0;
            rd_dly_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (!cs_n) begin
                    state_d   = S_CMD;
                    bit_cnt_d = '0;
                    shreg_d   = '0;
                end
                S_CMD: if (sck_rise) begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    shreg_d   = cmd_byte;
                    if (bit_cnt_q == 5'd7) begin
                        last_cmd_d = cmd_byte;
                        bit_cnt_d  = '0;
                        rose_d     = 1'b0;
                        id_idx_d   = '0;
                        shreg_d    = cmd_byte == SPI_CMD_JEDEC ? JEDEC_ID[23:16] : cmd_byte;
                        state_d    = cmd_byte == SPI_CMD_READ  ? S_ADDR :
                                     cmd_byte == SPI_CMD_JEDEC ? S_ID : S_IGNORE;
                    end
                end
                S_ADDR: begin
                    if (rd_dly_q) begin
                        shreg_d   = rom_data;
                        bit_cnt_d = '0;
                        rose_d    = 1'b0;
                        state_d   = S_DATA;
                    end else if (sck_rise && bit_cnt_q != ADDR_DONE) begin
                        addr_d    = full_addr[ADDR_W-2:0];
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == ADDR_LAST) begin
                            rd_d       = 1'b1;
                            rom_addr_d = full_addr;
                        end
                    end
                end
                // A falling edge only shifts once a rising edge of the byte has
                // been seen, so the edge trailing the command/address is ignored.
                S_DATA, S_ID: begin
                    if (state_q == S_DATA && rd_dly_q) next_byte_d = rom_data;
                    if (sck_rise) begin
                        rose_d    = 1'b1;
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (state_q == S_DATA && bit_cnt_q == 5'd0) begin
                            rd_d       = 1'b1;
                            rom_addr_d = rom_addr_q + ADDR_W'(1);
                        end
                    end else if (sck_fall && rose_q) begin
                        rose_d  = 1'b0;
                        shreg_d = shreg_q << 1;
                        if (bit_cnt_q == 5'd8) begin
                            bit_cnt_d = '0;
                            shreg_d   = state_q == S_DATA ? next_byte_q : id_byte;
                            id_idx_d  = id_idx_q + 2'(id_idx_q != 2'd3);
                        end
                    end
                end
                S_IGNORE: ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            addr_q      <= '0;
            next_byte_q <= '0;
            id_idx_q    <= '0;
            rose_q      <= 1'b0;
            rd_q        <= 1'b0;
            rd_dly_q    <= 1'b0;
            rom_addr_q  <= '0;
            last_cmd_q  <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            addr_q      <= addr_d;
            next_byte_q <= next_byte_d;
            id_idx_q    <= id_idx_d;
            rose_q      <= rose_d;
            rd_q        <= rd_d;
            rd_dly_q    <= rd_dly_d;
            rom_addr_q  <= rom_addr_d;
            last_cmd_q  <= last_cmd_d;
        end
    end

    assign spi.SPI_SO = (state_q == S_DATA || state_q == S_ID) ? shreg_q[7] : 1'b0;
    assign rom_rd_en  = rd_q;
    assign rom_addr   = rom_addr_q;
    assign active     = ~cs_n;
    assign last_cmd   = last_cmd_q;
endmodule

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder: SPI master driver, ROM model and reference checks for the flash responder
module tb_spi_flash_responder;
    import spi_flash_pkg::*;

    localparam int AW = 20;

    logic          CLK = 1'b0;
    logic          resetn = 1'b0;
    logic          rom_rd_en;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_data = 8'h00;
    logic          active;
    logic [7:0]    last_cmd;

    spi_flash_responder_if spi ();

    spi_flash_responder dut (
        .CLK       (CLK),
        .resetn    (resetn),
        .spi       (spi),
        .rom_rd_en (rom_rd_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .active    (active),
        .last_cmd  (last_cmd)
    );

    always #5 CLK = ~CLK;

    logic [7:0]    mem [0:(1<<AW)-1];
    int            rd_total = 0;
    logic [AW-1:0] rd_log [0:4095];

    always @(posedge CLK) begin
        if (rom_rd_en) begin
            rom_data                <= mem[rom_addr];
            rd_log[rd_total % 4096] <= rom_addr;
            rd_total                <= rd_total + 1;
        end
    end

    int          checks = 0;
    int          failures = 0;
    logic [63:0] rx;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic xbit(input logic b, input int h);
        spi.SPI_SI = b;
        clks(h);
        rx = {rx[62:0], spi.SPI_SO};
        spi.SPI_SCK = 1'b1;
        clks(h);
        spi.SPI_SCK = 1'b0;
    endtask

    task automatic cs_lo();
        spi.SPI_CS = 1'b0;
        clks(4);
        rx = '0;
    endtask

    task automatic cs_hi();
        clks(2);
        spi.SPI_CS = 1'b1;
        clks(8);
    endtask

    task automatic send(input logic [63:0] tx, input int nbits, input int h);
        for (int i = 0; i < nbits; i++) xbit(tx[63-i], h);
    endtask

    function automatic logic [63:0] hdr_bits(input logic [7:0] op, input logic [23:0] addr);
        return op == SPI_CMD_READ ? {op, addr, 32'h0} : {op, 56'h0};
    endfunction

    // Reference: a READ streams consecutive ROM bytes with wrap, JEDEC streams ID then 0xFF
    function automatic logic [39:0] model(input logic [7:0] op, input logic [23:0] addr, input int nb);
        logic [39:0] e = '0;
        logic [39:0] idb = {24'hEF4016, 16'hFFFF};
        for (int i = 0; i < nb; i++) begin
            if (op == SPI_CMD_READ)       e = {e[31:0], mem[(int'(addr) + i) % (1 << AW)]};
            else if (op == SPI_CMD_JEDEC) e = {e[31:0], idb[39-8*i -: 8]};
            else                          e = {e[31:0], 8'h00};
        end
        return e;
    endfunction

    task automatic run_check(input string tag, input logic [7:0] op, input logic [23:0] addr,
                             input int nb, input int h, input logic [39:0] exp, input int exp_rd);
        int          base;
        int          hdr;
        logic [63:0] got;
        base = rd_total;
        hdr  = op == SPI_CMD_READ ? 4 : 1;
        cs_lo();
        send(hdr_bits(op, addr), (hdr + nb) * 8, h);
        cs_hi();
        got = rx & ((64'h1 << (nb * 8)) - 64'h1);
        chk({tag, " data"}, got, 64'(exp));
        chk({tag, " rd_count"}, 64'(rd_total - base), 64'(exp_rd));
        chk({tag, " last_cmd"}, 64'(last_cmd), 64'(op));
        chk({tag, " so_idle"}, 64'(spi.SPI_SO), 64'h0);
        chk({tag, " inactive"}, 64'(active), 64'h0);
        for (int k = 0; k < exp_rd; k++)
            chk({tag, " rom_addr_seq"}, 64'(rd_log[(base + k) % 4096]),
                64'((int'(addr) + k) % (1 << AW)));
    endtask

    typedef struct {
        string       name;
        logic [7:0]  op;
        logic [23:0] addr;
        int          nb;
        int          h;
        logic [39:0] exp;
        int          exp_rd;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int          base;
        logic [7:0]  op;
        logic [23:0] addr;
        int          nb;
        int          sel;
        spi.SPI_CS  = 1'b1;
        spi.SPI_SCK = 1'b0;
        spi.SPI_SI  = 1'b0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);
        mem[20'h00100] = 8'hDE;
        mem[20'h00101] = 8'hAD;
        mem[20'h00102] = 8'hBE;
        mem[20'h00103] = 8'hEF;
        mem[20'hFFFFF] = 8'h12;
        mem[20'h00000] = 8'h34;

        vecs[0] = '{"basic_read",  8'h03, 24'h000100, 4, 4, 40'hDEADBEEF,   5};
        vecs[1] = '{"wrap_read",   8'h03, 24'hAFFFFF, 2, 5, 40'h1234,       3};
        vecs[2] = '{"jedec",       8'h9F, 24'h000000, 5, 4, 40'hEF4016FFFF, 0};
        vecs[3] = '{"unknown_op",  8'h05, 24'h000000, 2, 4, 40'h0,          0};
        vecs[4] = '{"read_again",  8'h03, 24'h000100, 2, 6, 40'hDEAD,       3};

        clks(3);
        chk("reset so", 64'(spi.SPI_SO), 64'h0);
        chk("reset rd_en", 64'(rom_rd_en), 64'h0);
        chk("reset rom_addr", 64'(rom_addr), 64'h0);
        chk("reset active", 64'(active), 64'h0);
        chk("reset last_cmd", 64'(last_cmd), 64'h0);
        resetn = 1'b1;
        clks(4);

        for (int v = 0; v < 5; v++)
            run_check(vecs[v].name, vecs[v].op, vecs[v].addr, vecs[v].nb, vecs[v].h,
                      vecs[v].exp, vecs[v].exp_rd);

        // Abort during the address phase: no ROM read, back to idle quickly
        base = rd_total;
        cs_lo();
        send(hdr_bits(8'h03, 24'h000100), 20, 4);
        spi.SPI_CS = 1'b1;
        clks(3);
        chk("abort_addr active", 64'(active), 64'h0);
        chk("abort_addr so", 64'(spi.SPI_SO), 64'h0);
        clks(8);
        chk("abort_addr rd_count", 64'(rd_total - base), 64'h0);
        chk("abort_addr last_cmd", 64'(last_cmd), 64'h03);

        // Abort after 3 data bits: 0xDE<<3 puts a 1 on SO, then CS rise forces 0
        cs_lo();
        send(hdr_bits(8'h03, 24'h000100), 35, 4);
        clks(4);
        chk("abort_data so_before", 64'(spi.SPI_SO), 64'h1);
        spi.SPI_CS = 1'b1;
        clks(3);
        chk("abort_data so_after", 64'(spi.SPI_SO), 64'h0);
        clks(8);
        run_check("after_abort", 8'h03, 24'h000100, 1, 4, 40'hDE, 2);

        // Reset in the middle of a read clears every output immediately
        cs_lo();
        send(hdr_bits(8'h03, 24'h000100), 35, 4);
        clks(4);
        resetn = 1'b0;
        #1;
        chk("midreset so", 64'(spi.SPI_SO), 64'h0);
        chk("midreset rd_en", 64'(rom_rd_en), 64'h0);
        chk("midreset rom_addr", 64'(rom_addr), 64'h0);
        chk("midreset active", 64'(active), 64'h0);
        chk("midreset last_cmd", 64'(last_cmd), 64'h0);
        spi.SPI_CS = 1'b1;
        clks(3);
        resetn = 1'b1;
        clks(4);
        run_check("after_reset", 8'h03, 24'h000100, 2, 4, 40'hDEAD, 3);

        for (int r = 0; r < 25; r++) begin
            sel  = int'($urandom_range(0, 3));
            op   = sel < 2 ? SPI_CMD_READ : sel == 2 ? SPI_CMD_JEDEC : 8'($urandom);
            addr = 24'($urandom);
            nb   = int'($urandom_range(1, 4));
            run_check("random", op, addr, nb, int'($urandom_range(4, 7)), model(op, addr, nb),
                      op == SPI_CMD_READ ? nb + 1 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
